// File: rtl/ooo_types_pkg.sv
// Shared out-of-order core types: writeback packet and functional-unit indices.
package ooo_types_pkg;

  localparam int CB_DATA_W = 32;
  localparam int CB_TAG_W  = 4;

  localparam int FU_ARITH = 0;
  localparam int FU_MUL   = 1;
  localparam int FU_DIV   = 2;
  localparam int FU_LS    = 3;

  typedef struct packed {
    logic [CB_DATA_W-1:0] data;
    logic [CB_TAG_W-1:0]  tag;
    logic                 exc;
  } wb_packet_t;

endpackage

// File: rtl/ooo_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module ooo_rr_arbiter #(
  parameter int NUM_FU = 4,
  localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic [NUM_FU-1:0] req,
  input  logic [IDX_W-1:0]  rr_ptr,
  output logic [NUM_FU-1:0] gnt,
  output logic [IDX_W-1:0]  gnt_idx
);

  always_comb begin
    int  idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_FU;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/ooo_wb_arbiter.sv
// Completion-buffer write-port arbiter: one holding register per functional unit,
// round-robin grant, grant locked while the completion buffer stalls.
module ooo_wb_arbiter
  import ooo_types_pkg::*;
#(
  parameter int NUM_FU = 4,
  parameter int DATA_W = CB_DATA_W,
  parameter int TAG_W  = CB_TAG_W,
  localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic [NUM_FU-1:0]              fu_valid,
  output logic [NUM_FU-1:0]              fu_ready,
  input  logic [NUM_FU-1:0][DATA_W-1:0]  fu_data,
  input  logic [NUM_FU-1:0][TAG_W-1:0]   fu_tag,
  input  logic [NUM_FU-1:0]              fu_exc,
  output logic                           wb_valid,
  input  logic                           wb_ready,
  output logic [IDX_W-1:0]               wb_fu,
  output logic [DATA_W-1:0]              wb_data,
  output logic [TAG_W-1:0]               wb_tag,
  output logic                           wb_exc,
  input  logic                           flush
);

  logic [NUM_FU-1:0]             held;
  logic [NUM_FU-1:0][DATA_W-1:0] hold_data;
  logic [NUM_FU-1:0][TAG_W-1:0]  hold_tag;
  logic [NUM_FU-1:0]             hold_exc;
  logic [IDX_W-1:0]              rr_ptr;
  logic                          lock_vld;
  logic [IDX_W-1:0]              lock_idx;
  logic [NUM_FU-1:0]             arb_gnt, gnt;
  logic [IDX_W-1:0]              arb_idx, gnt_idx;
  logic                          wb_xfer;

  ooo_rr_arbiter #(.NUM_FU(NUM_FU)) u_arb (
    .req     (held),
    .rr_ptr  (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // A stalled grant is pinned so a late lower-index arrival cannot preempt it.
  assign gnt_idx  = lock_vld ? lock_idx : arb_idx;
  assign gnt      = lock_vld ? (NUM_FU'(1) << lock_idx) : arb_gnt;
  assign wb_valid = (|held) & ~flush;
  assign wb_xfer  = wb_valid & wb_ready;
  assign fu_ready = {NUM_FU{~flush}} & (~held | (gnt & {NUM_FU{wb_ready}}));

  assign wb_fu   = wb_valid ? gnt_idx            : '0;
  assign wb_data = wb_valid ? hold_data[gnt_idx] : '0;
  assign wb_tag  = wb_valid ? hold_tag[gnt_idx]  : '0;
  assign wb_exc  = wb_valid ? hold_exc[gnt_idx]  : 1'b0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      held      <= '0;
      hold_data <= '0;
      hold_tag  <= '0;
      hold_exc  <= '0;
      rr_ptr    <= '0;
      lock_vld  <= 1'b0;
      lock_idx  <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (flush) begin
          held[i] <= 1'b0;
        end else if (fu_valid[i] && fu_ready[i]) begin
          held[i]      <= 1'b1;
          hold_data[i] <= fu_data[i];
          hold_tag[i]  <= fu_tag[i];
          hold_exc[i]  <= fu_exc[i];
        end else if (gnt[i] && wb_xfer) begin
          held[i] <= 1'b0;
        end
      end
      lock_vld <= wb_valid & ~wb_ready;
      lock_idx <= gnt_idx;
      if (wb_xfer)
        rr_ptr <= (gnt_idx == IDX_W'(NUM_FU-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_ooo_wb_arbiter.sv
// Directed bench for ooo_wb_arbiter with a queue-level reference model checked every cycle.
module tb_ooo_wb_arbiter;
  import ooo_types_pkg::*;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [3:0]       fu_valid, fu_ready, fu_exc;
  logic [3:0][31:0] fu_data;
  logic [3:0][3:0]  fu_tag;
  logic             wb_valid, wb_ready, wb_exc, flush;
  logic [1:0]       wb_fu;
  logic [31:0]      wb_data;
  logic [3:0]       wb_tag;

  ooo_wb_arbiter #(.NUM_FU(4), .DATA_W(32), .TAG_W(4)) dut (
    .CLK(CLK), .nRST(nRST), .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_data(fu_data), .fu_tag(fu_tag), .fu_exc(fu_exc),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_fu(wb_fu),
    .wb_data(wb_data), .wb_tag(wb_tag), .wb_exc(wb_exc), .flush(flush)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;
  int wq[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_q(string nm, int n, int e0, int e1 = 0, int e2 = 0, int e3 = 0);
    int e[4];
    e = '{e0, e1, e2, e3};
    chk({nm, "_count"}, wq.size(), n);
    for (int i = 0; i < n && i < wq.size(); i++) chk({nm, "_order"}, wq[i], e[i]);
  endtask

  // Reference model: held entries, pointer, and the grant pinned while stalled.
  bit          m_held[4];
  logic [31:0] m_data[4];
  logic [3:0]  m_tag[4];
  bit          m_exc[4];
  int          m_ptr;
  int          m_cur;

  function automatic int m_grant();
    if (m_cur >= 0) return m_cur;
    for (int k = 0; k < 4; k++)
      if (m_held[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  function automatic bit m_ready(int i);
    return !flush && (!m_held[i] || (m_grant() == i && wb_ready));
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < 4; i++) begin
        m_held[i] = 0; m_data[i] = '0; m_tag[i] = '0; m_exc[i] = 0;
      end
      m_ptr = 0;
      m_cur = -1;
    end else begin
      int g;
      bit acc[4];
      g = m_grant();
      for (int i = 0; i < 4; i++) acc[i] = fu_valid[i] && m_ready(i);
      if (flush) begin
        for (int i = 0; i < 4; i++) m_held[i] = 0;
        m_cur = -1;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (acc[i]) begin
            m_held[i] = 1; m_data[i] = fu_data[i]; m_tag[i] = fu_tag[i]; m_exc[i] = fu_exc[i];
          end else if (g == i && wb_ready) begin
            m_held[i] = 0;
          end
        end
        if (g >= 0 && wb_ready) begin
          m_ptr = (g + 1) % 4;
          m_cur = -1;
        end else begin
          m_cur = g;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (nRST) begin
      int g;
      logic [3:0] er;
      logic ev;
      g = m_grant();
      ev = (g >= 0) && !flush;
      for (int i = 0; i < 4; i++) er[i] = m_ready(i);
      chk("m_fu_ready", fu_ready, er);
      chk("m_wb_valid", wb_valid, ev);
      if (ev) begin
        chk("m_wb_fu", wb_fu, g);
        chk("m_wb_data", wb_data, m_data[g]);
        chk("m_wb_tag", wb_tag, m_tag[g]);
        chk("m_wb_exc", wb_exc, m_exc[g]);
      end else begin
        chk("m_wb_zero", {wb_fu, wb_tag, wb_exc}, '0);
        chk("m_wb_data_zero", wb_data, '0);
      end
      if (wb_valid && wb_ready) wq.push_back(int'(wb_fu));
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, limit 100000 time units");
    $fatal(1);
  end

  initial begin
    logic [1:0]  s_fu;
    logic [31:0] s_data;
    logic [3:0]  s_tag;
    int seen;
    nRST = 0; fu_valid = '0; fu_data = '0; fu_tag = '0; fu_exc = '0;
    wb_ready = 1; flush = 0;
    #12 nRST = 1;
    @(negedge CLK);
    chk("rst_fu_ready", fu_ready, 4'hF);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);

    // single result from the divider
    step(); fu_valid = 4'b0100; fu_data[FU_DIV] = 32'hDEADBEEF; fu_tag[FU_DIV] = 4'd5;
    step(); fu_valid = '0;
    @(negedge CLK);
    chk("div_wb_valid", wb_valid, 1);
    chk("div_wb_fu", wb_fu, 2);
    chk("div_wb_data", wb_data, 32'hDEADBEEF);
    chk("div_wb_tag", wb_tag, 5);

    // unit 3 alone wraps the pointer back to 0
    step(); fu_valid = 4'b1000; fu_data[FU_LS] = 32'h33; fu_tag[FU_LS] = 4'd3;
    step(); fu_valid = '0;
    step(); step();
    wq.delete();

    // all four at once
    for (int i = 0; i < 4; i++) begin
      fu_data[i] = 32'hA000_0000 + i; fu_tag[i] = 4'(8 + i);
    end
    fu_exc = 4'b0100; fu_valid = 4'hF;
    step(); fu_valid = '0; fu_exc = '0;
    repeat (4) step();
    chk_q("rr_all4", 4, 0, 1, 2, 3);
    wq.delete();
    fu_valid = 4'b1010; fu_data[1] = 32'hB1; fu_data[3] = 32'hB3;
    step(); fu_valid = '0;
    repeat (2) step();
    chk_q("rr_wrap", 2, 1, 3);
    wq.delete();

    // stalled completion buffer, late unit 0 must not preempt
    wb_ready = 0; fu_valid = 4'b1010; fu_data[1] = 32'hC1; fu_data[3] = 32'hC3;
    fu_tag[1] = 4'd1; fu_tag[3] = 4'd3;
    step(); fu_valid = '0;
    @(negedge CLK);
    s_fu = wb_fu; s_data = wb_data; s_tag = wb_tag;
    chk("stall_first_fu", s_fu, 1);
    step(); fu_valid = 4'b0001; fu_data[0] = 32'hC0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("stall_fu", wb_fu, s_fu);
      chk("stall_data", wb_data, s_data);
      chk("stall_tag", wb_tag, s_tag);
      chk("stall_ready13", {fu_ready[3], fu_ready[1]}, 2'b00);
      step(); fu_valid = '0;
    end
    wb_ready = 1;
    repeat (3) step();
    chk_q("stall_release", 3, 1, 3, 0);
    wq.delete();

    // unit 0 streaming
    for (int k = 0; k < 6; k++) begin
      fu_valid = 4'b0001; fu_data[0] = 32'(100 + k); fu_tag[0] = 4'(k);
      @(negedge CLK);
      chk("stream_ready0", fu_ready[0], 1);
      step();
    end
    chk("stream_writes", wq.size(), 5);
    fu_valid = 4'b1001; fu_data[0] = 32'd200; fu_data[3] = 32'h3333;
    step(); fu_valid = 4'b0001; fu_data[0] = 32'd201;
    seen = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      if (wb_valid && wb_fu == 2'd3) seen = 1;
      step(); fu_valid = '0;
    end
    chk("stream_u3_granted", seen, 1);
    repeat (3) step();

    // flush with all four held and unit 1 presenting
    wb_ready = 0; fu_valid = 4'hF;
    step(); fu_valid = 4'b0010; fu_data[1] = 32'hF1; flush = 1;
    @(negedge CLK);
    chk("flush_fu_ready", fu_ready, 4'h0);
    chk("flush_wb_valid", wb_valid, 0);
    step(); flush = 0; fu_valid = '0;
    @(negedge CLK);
    chk("post_flush_wb_valid", wb_valid, 0);
    chk("post_flush_fu_ready", fu_ready, 4'hF);

    // asynchronous reset with two held entries, pointer parked at 2
    step(); wb_ready = 1; fu_valid = 4'b0010;
    step(); fu_valid = '0;
    step(); wb_ready = 0; fu_valid = 4'b0101;
    step(); fu_valid = '0;
    @(negedge CLK);
    chk("pre_rst_wb_valid", wb_valid, 1);
    #2 nRST = 0;
    #1;
    chk("async_rst_wb_valid", wb_valid, 0);
    chk("async_rst_fu_ready", fu_ready, 4'hF);
    step(); nRST = 1; wb_ready = 1;
    @(negedge CLK);
    chk("post_rst_fu_ready", fu_ready, 4'hF);
    wq.delete();
    step(); fu_valid = 4'b1010;
    step(); fu_valid = '0;
    repeat (2) step();
    chk_q("post_rst_ptr0", 2, 1, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ooo_wb_arbiter.md
# ooo_wb_arbiter

Shares the single completion-buffer write port among the out-of-order core's functional units: arithmetic, multiply, divide and load/store. Each unit hands its finished result to the arbiter through a valid/ready handshake. The arbiter parks the result in a one-entry holding register for that unit, then grants the write port round-robin. It sits between the functional-unit output latches and the completion buffer, and its per-unit `fu_ready` is the back-pressure the hazard unit folds into its stall logic.

## Interface
Parameters:
- `NUM_FU`, 4: number of requesting functional units (index 0 = arith, 1 = mul, 2 = div, 3 = load/store).
- `DATA_W`, 32: result width.
- `TAG_W`, 4: completion-buffer entry index width.

Ports (one clock; reset is asynchronous and active-low):
- `CLK` in 1: clock.
- `nRST` in 1: asynchronous active-low reset.
- `fu_valid` in NUM_FU: unit i presents a result.
- `fu_ready` out NUM_FU: arbiter accepts unit i's result this cycle.
- `fu_data` in NUM_FU×DATA_W: result value per unit.
- `fu_tag` in NUM_FU×TAG_W: completion-buffer index per unit.
- `fu_exc` in NUM_FU: result carries an exception.
- `wb_valid` out 1: write-port request to the completion buffer.
- `wb_ready` in 1: completion buffer accepts the write.
- `wb_fu` out $clog2(NUM_FU): granted unit index.
- `wb_data` out DATA_W: granted result.
- `wb_tag` out TAG_W: granted index.
- `wb_exc` out 1: granted exception flag.
- `flush` in 1: mispredict or interrupt flush; discard everything held.

## Operation
- Per-unit state:
  - `held[i]` is the valid bit of holding register i.
  - Each holding register stores data, tag and exc.
- Handshakes:
  - Unit transfer occurs when `fu_valid[i] & fu_ready[i]`.
  - Write transfer occurs when `wb_valid & wb_ready`.
- `fu_ready[i] = ~flush & (~held[i] | (grant[i] & wb_ready))`. A unit whose entry drains this cycle can refill in the same cycle.
- `wb_valid = |held & ~flush`.
- `grant` is one-hot over `held` and is chosen round-robin starting at pointer `rr_ptr`.
- `wb_*` outputs are driven combinationally from the granted holding register. When `wb_valid` = 0 they are zero.
- Update rules:
  - Transfer into i: `held[i]` is set to 1 and the payload is loaded.
  - Grant to i with `wb_ready` and no refill: `held[i]` is cleared.
  - Drain and refill in the same cycle: `held[i]` stays 1 and the new payload is loaded.
- Round-robin pointer:
  - On a write transfer granted to i: `rr_ptr` ← (i+1) mod NUM_FU.
  - Otherwise `rr_ptr` is unchanged, including when `wb_valid` = 1 but `wb_ready` = 0.
- Grant stability: while `wb_valid` = 1 and `wb_ready` = 0, grant and payload stay stable cycle to cycle. A newly arriving lower-index request does not preempt the current grant.
- Flush:
  - Clears all `held` bits on the next edge.
  - Forces `fu_ready` = 0 and `wb_valid` = 0 in the flush cycle.
  - `rr_ptr` is unchanged.
  - Flush has priority over every simultaneous transfer.
- Fairness: a holding unit is granted within NUM_FU write transfers.

## Timing
- Reset values: `held` = 0, payload registers = 0, `rr_ptr` = 0. Therefore `wb_valid` = 0, `wb_*` = 0, and `fu_ready` = all 1s.
- Latency: a result accepted at edge N can appear on `wb_*` in cycle N+1. There is no combinational path from `fu_valid` to `wb_valid`.
- Throughput: one write per cycle. A single unit streaming alone with `wb_ready` held at 1 sustains one result per cycle.
- Reset asserted mid-operation clears all state asynchronously. Pending results are lost, matching a pipeline flush.

## Structure
- Add `wb_packet_t` (data, tag, exc) and the FU index localparams (`FU_ARITH`, `FU_MUL`, `FU_DIV`, `FU_LS`) to `ooo_types_pkg`. The dispatcher and completion buffer reuse both.
- One sub-module, `ooo_rr_arbiter`:
  - Inputs: request vector, `rr_ptr`.
  - Outputs: one-hot grant and its encoded index.
  - Purely combinational.
  - Parameterised on NUM_FU.
- The top level holds the holding registers, `rr_ptr` and the handshake logic.

## Test plan
- Reset then idle: after `nRST` low and release, require `fu_ready` = 4'b1111 and `wb_valid` = 0. Then unit 2 sends data 0xDEADBEEF, tag 5 → next cycle `wb_valid` = 1, `wb_fu` = 2, `wb_data` = 0xDEADBEEF, `wb_tag` = 5.
- All four units valid in the same cycle with `wb_ready` = 1 → grants in order 0, 1, 2, 3 on consecutive cycles. Then with units 1 and 3 re-requesting, grants are 1, 3 (pointer has wrapped to 0).
- `wb_ready` = 0 for 3 cycles with units 1 and 3 held → `wb_fu`, `wb_data` and `wb_tag` stay constant, and `fu_ready[1]` = `fu_ready[3]` = 0. On release, grant 1 then 3.
- Unit 0 streams a value every cycle with `wb_ready` = 1 → `fu_ready[0]` stays 1 and one write per cycle appears with a 1-cycle lag. Then unit 3 asserts → unit 3 is granted within 2 cycles.
- `flush` asserted while all four are held and unit 1 is presenting new data → in the flush cycle `fu_ready` = 0 and `wb_valid` = 0. The next cycle `held` = 0 and no write is issued.
- Assert `nRST` low while 2 entries are held and `wb_ready` = 0 → `wb_valid` drops immediately (asynchronous). After release, `rr_ptr` = 0 and `fu_ready` = 4'b1111.
